turbo_tx_itl: RTL
=================

Name: turbo_tx_itl

Overview:
Transmit-side turbo interleaver for the HPGP turbo encoder path. It buffers one physical block (PB) of dibits in natural order. It then streams two sequences in lock-step, each as a 2-bit pair: the natural-order dibit for the systematic/first constituent encoder and the interleaved-order dibit for the second constituent encoder. It sits between the scrambler/PB framer and the turbo encoder, and its permutation is the inverse partner of the RX deinterleaver.

Parameters:
DW, 2, dibit width in bits
S16, 23, interleaver step for PB16 (L=64)
S136, 179, interleaver step for PB136 (L=544)
S520, 1021, interleaver step for PB520 (L=2080)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
pb_size  input  2  0=PB16, 1=PB136, 2=PB520, 3=reserved; sampled on accepted start
start  input  1  one-cycle pulse, begins a new PB
din  input  2  natural-order input dibit
din_vld  input  1  din valid
in_rdy  output  1  high while block accepts din (FILL state)
dout_nat  output  2  natural-order dibit mem[x]
dout_itl  output  2  interleaved dibit mem[I(x)]
dout_vld  output  1  dout_nat/dout_itl valid
dout_last  output  1  marks x = L-1, qualified by dout_vld
dout_rdy  input  1  downstream accepts the output pair
busy  output  1  state != IDLE
err  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset (rst=1 at clk edge, any state): state=IDLE; in_rdy, dout_vld, dout_last, busy and err = 0; dout_nat and dout_itl = 0; all counters = 0. Memory contents are don't-care. Reset mid-FILL or mid-DRAIN aborts the PB with no further output.
- L and S are selected from the latched pb_size: 64/S16, 544/S136, 2080/S520.
- Permutation: I(x) = (S*x) mod L for x = 0..L-1. gcd(S,L)=1 for all sizes, so I is a bijection.
  - Computed incrementally, with no multiplier: I(0)=0; I(x+1) = I(x)+S, minus L if the sum is >= L. A single subtract suffices because S < L.
- Storage: 2080 x DW. One write port. Two read ports (x and I(x)) or equivalent.
- States:
  - IDLE:
    - start with pb_size in 0..2 -> latch size, wptr=0, go to FILL.
    - start with pb_size=3 -> err pulse, stay in IDLE.
    - din_vld is ignored.
  - FILL:
    - in_rdy=1. Each din_vld writes din at mem[wptr] and increments wptr.
    - The write with wptr=L-1 goes to DRAIN on the next cycle, with x=0 and I=0.
    - start is ignored and pulses err.
  - DRAIN:
    - in_rdy=0. din_vld while in_rdy=0 is dropped and pulses err.
    - The output register loads mem[x] and mem[I(x)] when (!dout_vld || dout_rdy). On each load, x and I advance.
    - dout_last=1 on the register load for x=L-1.
    - When dout_vld && dout_rdy && dout_last occur together, dout_vld drops the next cycle and the state returns to IDLE.
    - start is ignored and pulses err.
- Latency: the last FILL write is in cycle N. State is DRAIN in cycle N+1. The first dout_vld (x=0) is in cycle N+2. With dout_rdy held high, output is one pair per cycle with no bubbles, and L pairs end in cycle N+L+1.
- Hold rule: while dout_vld=1 and dout_rdy=0, dout_nat, dout_itl and dout_last are stable and x/I do not advance.
- A start in the same cycle as the final DRAIN handshake is ignored, with an err pulse. The next PB needs start in IDLE.
- Back-to-back: earliest next start is the first cycle busy=0.

Test Plan:
1. PB16: pb_size=0, start, then 64 dibits with din=k mod 4, dout_rdy=1 -> dout_nat = 0,1,2,3,...; dout_itl addresses 0,23,46,5,28,... give values 0,3,2,1,0,... Last I = 41, value 1. dout_last on pair 64. First dout_vld exactly 2 cycles after the last din.
2. PB520 coverage: random din, dout_rdy=1 -> 2080 pairs. The scoreboard confirms each address is read once by dout_itl and that I(2079)=1059. PB136 likewise: 544 pairs, I(543)=365.
3. Backpressure: PB16 with dout_rdy toggled randomly, including low on the dout_last cycle -> outputs held stable while stalled. The sequence is identical to test 1, and there is no loss or duplication.
4. Errors:
   - pb_size=3 with start -> err for 1 cycle, busy stays 0.
   - din_vld during DRAIN -> err pulse, output sequence unaffected.
   - start during FILL -> err pulse, fill continues.
5. Reset mid-operation: assert rst at pair 300 of a PB136 DRAIN -> next cycle all outputs 0 and state IDLE. A following PB16 run then passes test 1 exactly.
6. Back-to-back: PB16 then PB520, with the second start on the first busy=0 cycle -> both streams correct and the pb_size latch is independent between the two PBs.

Source files
------------

// File: rtl/turbo_tx_itl.sv
// Transmit turbo interleaver: buffers one PB of dibits, then streams
// natural-order and (S*x mod L)-interleaved dibits in lock-step.
module turbo_tx_itl #(
   parameter int DW   = 2,
   parameter int S16  = 23,
   parameter int S136 = 179,
   parameter int S520 = 1021
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    pb_size,
   input  logic          start,
   input  logic [DW-1:0] din,
   input  logic          din_vld,
   output logic          in_rdy,
   output logic [DW-1:0] dout_nat,
   output logic [DW-1:0] dout_itl,
   output logic          dout_vld,
   output logic          dout_last,
   input  logic          dout_rdy,
   output logic          busy,
   output logic          err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [1:0]    sz;
   logic [11:0]   len, step;
   logic [11:0]   wptr, x, idx;
   logic [11:0]   idx_sum, idx_nxt;
   logic [DW-1:0] mem [0:2079];

   logic accept_start, wr_en, wr_last;
   logic load, finish, proto_err;

   always_comb begin
      len  = 12'd64;
      step = 12'(S16);
      case (sz)
         2'd1: begin
            len  = 12'd544;
            step = 12'(S136);
         end
         2'd2: begin
            len  = 12'd2080;
            step = 12'(S520);
         end
         default: ;
      endcase
   end

   // S < L, so one conditional subtract keeps idx in range
   assign idx_sum = idx + step;
   assign idx_nxt = (idx_sum >= len) ? idx_sum - len : idx_sum;

   assign accept_start = (state == IDLE) && start && (pb_size != 2'd3);
   assign wr_en        = (state == FILL) && din_vld;
   assign wr_last      = wr_en && (wptr == len - 12'd1);
   assign load         = (state == DRAIN) && !(dout_vld && dout_last)
                         && (!dout_vld || dout_rdy);
   assign finish       = (state == DRAIN) && dout_vld && dout_last
                         && dout_rdy;
   assign proto_err    = (start && ((state != IDLE) || (pb_size == 2'd3)))
                         || (din_vld && (state == DRAIN));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_start) state_nxt = FILL;
         FILL:    if (wr_last)      state_nxt = DRAIN;
         DRAIN:   if (finish)       state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_rdy = (state == FILL);
      busy   = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sz        <= 2'd0;
         wptr      <= 12'd0;
         x         <= 12'd0;
         idx       <= 12'd0;
         dout_nat  <= '0;
         dout_itl  <= '0;
         dout_vld  <= 1'b0;
         dout_last <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= proto_err;
         if (accept_start) begin
            sz   <= pb_size;
            wptr <= 12'd0;
         end
         if (wr_en) wptr <= wptr + 12'd1;
         if (wr_last) begin
            x   <= 12'd0;
            idx <= 12'd0;
         end
         if (load) begin
            dout_nat  <= mem[x];
            dout_itl  <= mem[idx];
            dout_last <= (x == len - 12'd1);
            dout_vld  <= 1'b1;
            x         <= x + 12'd1;
            idx       <= idx_nxt;
         end else if (finish) begin
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
         end
      end
   end

endmodule
